// File: rtl/sev_seg_mux.sv
// rtl/sev_seg_mux.sv - multiplexed seven-segment driver with iterative double-dabble BCD conversion
// Optional PWM dimming of the anodes is enabled by defining SEV_SEG_PWM_EN.
module sev_seg_mux #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4,
  parameter int VAL_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp,
`ifdef SEV_SEG_PWM_EN
  input  logic [3:0]        brightness,
`endif
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic              dp_n,
  output logic [DIGITS-1:0] an
);
  localparam int P    = CLK_HZ / SCAN_HZ;
  localparam int PW   = (P > 1) ? $clog2(P) : 1;
  localparam int NIB  = (VAL_W * 30103) / 100000 + 2;
  localparam int BW   = 4 * NIB;
  localparam int HN   = (VAL_W + 3) / 4;
  localparam int CN   = (NIB > HN) ? NIB : HN;
  // One spare nibble keeps the overflow slice non-empty even when every digit fits.
  localparam int MAXN = ((CN > DIGITS) ? CN : DIGITS) + 1;
  localparam int SW   = 4 * MAXN;
  localparam int CW   = $clog2(VAL_W + 1);
  localparam int DSW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [VAL_W-1:0]    val_q, val_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hex_q, hex_d, blz_q, blz_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d, blank_q, blank_d;
  logic [BW-1:0]       adj;
  logic [SW-1:0]       src;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    blz_d   = blz_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;
    adj     = bcd_q;
    src     = '0;
    for (int i = 0; i < NIB; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    if (hex_q) src[VAL_W-1:0] = val_q;
    else       src[BW-1:0]    = bcd_q;
    case (state_q)
      IDLE: if (load) begin
        val_d   = value;
        hex_d   = hex_mode;
        blz_d   = blank_lz;
        bcd_d   = '0;
        cnt_d   = CW'(VAL_W);
        state_d = hex_mode ? COMMIT : SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[BW-2:0], val_q[VAL_W-1]};
        val_d = val_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = src[4*DIGITS-1:0];
        ovf_d   = |src[SW-1:4*DIGITS];
        blank_d = blz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      blz_q   <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blz_q   <= blz_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic [DSW-1:0]    sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic              dpn_q, dpn_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] lead0;
  logic [3:0]        nib;
  logic              seen;

  always_comb begin
    presc_d = presc_q + PW'(1);
    sel_d   = sel_q;
    if (presc_q == PW'(P - 1)) begin
      presc_d = '0;
      sel_d   = (sel_q == DSW'(DIGITS - 1)) ? '0 : sel_q + DSW'(1);
    end
    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    seen  = 1'b0;
    lead0 = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (disp_q[4*i +: 4] != 4'd0);
      lead0[i] = !seen && (i != 0);
    end
    nib   = disp_q[4*sel_q +: 4];
    seg_d = enc(nib);
    if (ovf_q)                         seg_d = 7'b0111111;
    else if (blank_q && lead0[sel_q])  seg_d = 7'h7F;
    dpn_d = ~dp[sel_q];
    an_d  = ~(DIGITS'(1) << sel_q);
`ifdef SEV_SEG_PWM_EN
    if (((32'(presc_q) * 16) / P) > 32'(brightness)) an_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sel_q   <= '0;
      seg_q   <= 7'h7F;
      dpn_q   <= 1'b1;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      an_q    <= an_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign dp_n     = dpn_q;
  assign an       = an_q;
endmodule

// File: tb/tb_sev_seg_mux.sv
// tb/tb_sev_seg_mux.sv - scoreboard bench for sev_seg_mux (4-digit and 2-digit instances)
module tb_sev_seg_mux;
  localparam int P = 10;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       load = 1'b0, hex_mode = 1'b0, blank_lz = 1'b0;
  logic [3:0] dp = 4'b0010;
  logic       sel = 1'b0;
  logic       load4, load2;
  logic       busy4, ovf4, dpn4, busy2, ovf2, dpn2;
  logic [6:0] seg4, seg2;
  logic [3:0] an4;
  logic [1:0] an2;
  logic       m_busy, m_ovf, m_dpn;
  logic [6:0] m_seg;
  logic [3:0] m_an;

  always #5 clk = ~clk;

  assign load4 = load & ~sel;
  assign load2 = load & sel;

  sev_seg_mux #(.CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .VAL_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .load(load4), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp(dp), .busy(busy4), .overflow(ovf4), .seg(seg4),
    .dp_n(dpn4), .an(an4));

  sev_seg_mux #(.CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(2), .VAL_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .value(value), .load(load2), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp(dp[1:0]), .busy(busy2), .overflow(ovf2), .seg(seg2),
    .dp_n(dpn2), .an(an2));

  assign m_busy = sel ? busy2 : busy4;
  assign m_ovf  = sel ? ovf2  : ovf4;
  assign m_dpn  = sel ? dpn2  : dpn4;
  assign m_seg  = sel ? seg2  : seg4;
  assign m_an   = sel ? {2'b11, an2} : an4;

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dpn;
    logic        ovf;
    int          blen;
    int          nd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;
  bit   mon_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  initial begin : monitor
    int         bcnt, nlow, idx, nbad_oh;
    exp_t       e;
    logic [6:0] got_seg [4];
    logic       got_dpn [4];
    bit         seen [4];
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) bcnt = 0;
      else if (m_busy) bcnt++;
      else if (bcnt != 0) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) chk("unexpected_conversion", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("busy_cycles", bcnt, e.blen);
          chk("overflow", {31'd0, m_ovf}, {31'd0, e.ovf});
          for (int i = 0; i < 4; i++) seen[i] = 1'b0;
          nbad_oh = 0;
          repeat (e.nd * P + 2) begin
            @(negedge clk);
            nlow = 0;
            idx  = 0;
            for (int i = 0; i < 4; i++) if (!m_an[i]) begin nlow++; idx = i; end
            if (nlow == 1) begin
              got_seg[idx] = m_seg;
              got_dpn[idx] = m_dpn;
              seen[idx]    = 1'b1;
            end else nbad_oh++;
          end
          chk("an_onehot_errors", nbad_oh, 0);
          for (int i = 0; i < e.nd; i++) begin
            chk($sformatf("seg_digit%0d", i), seen[i] ? {25'd0, got_seg[i]} : 32'hFFFF_FFFF,
                {25'd0, e.segs[7*i +: 7]});
            chk($sformatf("dpn_digit%0d", i), {30'd0, seen[i], got_dpn[i]}, {30'd0, 1'b1, e.dpn[i]});
          end
        end
        bcnt = 0;
        mon_active = 1'b0;
      end
    end
  end

  task automatic push(input logic [27:0] segs, input logic ovf, input int blen, input int nd);
    exp_t e;
    e.segs = segs;
    e.dpn  = ~dp;
    e.ovf  = ovf;
    e.blen = blen;
    e.nd   = nd;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] v, input logic hx, input logic blz);
    @(negedge clk);
    value = v; hex_mode = hx; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, n >= 300}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    logic [3:0] exp_an;
    int         nbad;
    repeat (3) @(negedge clk);
    chk("reset_outputs4", {busy4, ovf4, dpn4, an4, seg4}, {1'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
    chk("reset_outputs2", {busy2, ovf2, dpn2, an2, seg2}, {1'b0, 1'b0, 1'b1, 2'b11, 7'h7F});
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((k - 1) / 10) % 4));
      chk($sformatf("reset_scan%0d", k), {busy4, an4, seg4}, {1'b0, exp_an, 7'h40});
    end

    push({7'h40, 7'h24, 7'h12, 7'h12}, 1'b0, 9, 4);
    do_load(8'd255, 1'b0, 1'b0);
    wait_idle();
    push({7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0, 9, 4);
    do_load(8'd7, 1'b0, 1'b1);
    wait_idle();
    push({7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 9, 4);
    do_load(8'd0, 1'b0, 1'b1);
    wait_idle();
    push({7'h40, 7'h40, 7'h08, 7'h03}, 1'b0, 1, 4);
    do_load(8'hAB, 1'b1, 1'b0);
    wait_idle();
    push({7'h7F, 7'h7F, 7'h7F, 7'h0E}, 1'b0, 1, 4);
    do_load(8'h0F, 1'b1, 1'b1);
    wait_idle();
    push({7'h7F, 7'h7F, 7'h79, 7'h40}, 1'b0, 1, 4);
    do_load(8'h10, 1'b1, 1'b1);
    wait_idle();
    push({7'h40, 7'h24, 7'h40, 7'h40}, 1'b0, 9, 4);
    do_load(8'd200, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    do_load(8'h12, 1'b1, 1'b1);
    wait_idle();

    sel = 1'b1;
    push({14'd0, 7'h3F, 7'h3F}, 1'b1, 9, 2);
    do_load(8'd255, 1'b0, 1'b0);
    wait_idle();
    push({14'd0, 7'h19, 7'h24}, 1'b0, 9, 2);
    do_load(8'd42, 1'b0, 1'b0);
    wait_idle();
    push({14'd0, 7'h3F, 7'h3F}, 1'b1, 9, 2);
    do_load(8'd100, 1'b0, 1'b1);
    wait_idle();
    sel = 1'b0;

    do_load(8'd255, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midconv_reset", {busy4, ovf4, dpn4, an4, seg4}, {1'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
    @(negedge clk);
    rst = 1'b0;
    nbad = 0;
    repeat (45) begin
      @(negedge clk);
      if (seg4 !== 7'h40 || busy4 !== 1'b0 || ovf4 !== 1'b0) nbad++;
    end
    chk("post_reset_display_zero_errors", nbad, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
